// File: rtl/shape_overlay.sv
// Multi-circle overlay: keypad-edited objects with per-frame shadow copy and a
// 3-stage pixel pipeline (distance, hit test, priority colour select).
module shape_overlay #(
   parameter int NUM_OBJ = 4,
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int STEP_XY = 20,
   parameter int STEP_R  = 5,
   parameter int R_MIN   = 5,
   parameter int R_MAX   = 200,
   parameter int R_INIT  = 15,
   parameter logic [NUM_OBJ*12-1:0] OBJ_COLORS = {12'hff0, 12'h00f, 12'h0f0, 12'hf00},
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  i_key_code,
   input  logic        i_key_ready,
   input  logic        i_frame_start,
   input  logic [9:0]  i_col_addr,
   input  logic [8:0]  i_row_addr,
   output logic [11:0] o_vga_data,
   output logic [2:0]  o_sel,
   output logic [9:0]  o_sel_x,
   output logic [8:0]  o_sel_y,
   output logic [9:0]  o_sel_r,
   output logic        o_sel_en
);

   logic               r_prev_ready;
   logic [2:0]         r_sel;
   logic [9:0]         r_wx [NUM_OBJ];
   logic [8:0]         r_wy [NUM_OBJ];
   logic [9:0]         r_wr [NUM_OBJ];
   logic [NUM_OBJ-1:0] r_wen;
   logic [9:0]         r_disp_x [NUM_OBJ];
   logic [8:0]         r_disp_y [NUM_OBJ];
   logic [9:0]         r_disp_r [NUM_OBJ];
   logic [NUM_OBJ-1:0] r_disp_en;
   logic [9:0]         r_dx [NUM_OBJ];
   logic [8:0]         r_dy [NUM_OBJ];
   logic [NUM_OBJ-1:0] r_hit;
   logic [11:0]        r_vga;

   logic        w_fire;
   logic [2:0]  w_nsel;
   logic [9:0]  w_cur_x, w_cur_r, w_nx, w_nr;
   logic [8:0]  w_cur_y, w_ny;
   logic        w_cur_en, w_nen;
   logic [10:0] w_x_inc, w_x_dec, w_r_inc, w_r_dec;
   logic [9:0]  w_y_inc, w_y_dec;
   logic [9:0]  w_dx [NUM_OBJ];
   logic [8:0]  w_dy [NUM_OBJ];
   logic [NUM_OBJ-1:0] w_hit;
   logic [11:0] w_pix;

   assign w_fire = i_key_ready & ~r_prev_ready;
   assign w_nsel = (r_sel == 3'(NUM_OBJ-1)) ? 3'd0 : r_sel + 3'd1;

   always_comb begin
      w_cur_x  = '0;
      w_cur_y  = '0;
      w_cur_r  = '0;
      w_cur_en = 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (r_sel == 3'(i)) begin
            w_cur_x  = r_wx[i];
            w_cur_y  = r_wy[i];
            w_cur_r  = r_wr[i];
            w_cur_en = r_wen[i];
         end
      end
      // one extra bit catches borrow on decrement and overflow on increment
      w_x_inc = {1'b0, w_cur_x} + 11'(STEP_XY);
      w_x_dec = {1'b0, w_cur_x} - 11'(STEP_XY);
      w_y_inc = {1'b0, w_cur_y} + 10'(STEP_XY);
      w_y_dec = {1'b0, w_cur_y} - 10'(STEP_XY);
      w_r_inc = {1'b0, w_cur_r} + 11'(STEP_R);
      w_r_dec = {1'b0, w_cur_r} - 11'(STEP_R);
      w_nx  = w_cur_x;
      w_ny  = w_cur_y;
      w_nr  = w_cur_r;
      w_nen = w_cur_en;
      case (i_key_code)
         5'h0C: w_nx = w_x_dec[10] ? 10'd0 : w_x_dec[9:0];
         5'h0E: w_nx = (w_x_inc > 11'(H_RES-1)) ? 10'(H_RES-1) : w_x_inc[9:0];
         5'h09: w_ny = w_y_dec[9] ? 9'd0 : w_y_dec[8:0];
         5'h11: w_ny = (w_y_inc > 10'(V_RES-1)) ? 9'(V_RES-1) : w_y_inc[8:0];
         5'h10: w_nr = (w_r_dec[10] || (w_r_dec < 11'(R_MIN))) ? 10'(R_MIN) : w_r_dec[9:0];
         5'h12: w_nr = (w_r_inc > 11'(R_MAX)) ? 10'(R_MAX) : w_r_inc[9:0];
         5'h01: w_nen = ~w_cur_en;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_prev_ready <= 1'b1;
         r_sel        <= '0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            r_wx[i]      <= 10'((i+1)*H_RES/(NUM_OBJ+1));
            r_wy[i]      <= 9'(V_RES/2);
            r_wr[i]      <= 10'(R_INIT);
            r_wen[i]     <= 1'b1;
            r_disp_x[i]  <= 10'((i+1)*H_RES/(NUM_OBJ+1));
            r_disp_y[i]  <= 9'(V_RES/2);
            r_disp_r[i]  <= 10'(R_INIT);
            r_disp_en[i] <= 1'b1;
         end
      end else begin
         r_prev_ready <= i_key_ready;
         if (w_fire && i_key_code == 5'h00)
            r_sel <= w_nsel;
         // display copy reads pre-edit values when an edit lands on frame_start
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (w_fire && r_sel == 3'(i)) begin
               r_wx[i]  <= w_nx;
               r_wy[i]  <= w_ny;
               r_wr[i]  <= w_nr;
               r_wen[i] <= w_nen;
            end
            if (i_frame_start) begin
               r_disp_x[i]  <= r_wx[i];
               r_disp_y[i]  <= r_wy[i];
               r_disp_r[i]  <= r_wr[i];
               r_disp_en[i] <= r_wen[i];
            end
         end
      end
   end

   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         w_dx[i] = (i_col_addr >= r_disp_x[i]) ? i_col_addr - r_disp_x[i] : r_disp_x[i] - i_col_addr;
         w_dy[i] = (i_row_addr >= r_disp_y[i]) ? i_row_addr - r_disp_y[i] : r_disp_y[i] - i_row_addr;
         w_hit[i] = r_disp_en[i] &&
                    (({1'b0, 20'(r_dx[i]) * 20'(r_dx[i])} + {3'b0, 18'(r_dy[i]) * 18'(r_dy[i])})
                     <= {1'b0, 20'(r_disp_r[i]) * 20'(r_disp_r[i])});
      end
      w_pix = BG_COLOR;
      for (int i = NUM_OBJ-1; i >= 0; i--) begin
         if (r_hit[i])
            w_pix = OBJ_COLORS[12*i +: 12];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            r_dx[i] <= '0;
            r_dy[i] <= '0;
         end
         r_hit <= '0;
         r_vga <= BG_COLOR;
      end else begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            r_dx[i] <= w_dx[i];
            r_dy[i] <= w_dy[i];
         end
         r_hit <= w_hit;
         r_vga <= w_pix;
      end
   end

   assign o_vga_data = r_vga;
   assign o_sel      = r_sel;
   assign o_sel_x    = w_cur_x;
   assign o_sel_y    = w_cur_y;
   assign o_sel_r    = w_cur_r;
   assign o_sel_en   = w_cur_en;

endmodule

// File: tb/tb_shape_overlay.sv
// Directed bench for shape_overlay: object model plus pixel scoreboard queue.
module tb_shape_overlay;

   logic        clk = 1'b0;
   logic        rstn;
   logic [4:0]  key_code;
   logic        key_ready;
   logic        frame_start;
   logic [9:0]  col_addr;
   logic [8:0]  row_addr;
   logic [11:0] vga_data;
   logic [2:0]  sel;
   logic [9:0]  sel_x;
   logic [8:0]  sel_y;
   logic [9:0]  sel_r;
   logic        sel_en;

   shape_overlay dut (
      .clk(clk), .rstn(rstn),
      .i_key_code(key_code), .i_key_ready(key_ready), .i_frame_start(frame_start),
      .i_col_addr(col_addr), .i_row_addr(row_addr),
      .o_vga_data(vga_data), .o_sel(sel), .o_sel_x(sel_x), .o_sel_y(sel_y),
      .o_sel_r(sel_r), .o_sel_en(sel_en)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int wx[4], wy[4], wr[4], dx[4], dy[4], dr[4];
   bit wen[4], den[4];
   int ms;
   logic [11:0] q[$];
   logic [11:0] cols[4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cols[0] = 12'hf00; cols[1] = 12'h0f0; cols[2] = 12'h00f; cols[3] = 12'hff0;
      for (int i = 0; i < 4; i++) begin
         wx[i] = (i+1)*640/5; wy[i] = 240; wr[i] = 15; wen[i] = 1'b1;
         dx[i] = wx[i]; dy[i] = wy[i]; dr[i] = wr[i]; den[i] = 1'b1;
      end
      ms = 0;
   endtask

   task automatic model_frame();
      for (int i = 0; i < 4; i++) begin
         dx[i] = wx[i]; dy[i] = wy[i]; dr[i] = wr[i]; den[i] = wen[i];
      end
   endtask

   task automatic apply_key(input int c);
      case (c)
         'h0C: wx[ms] = (wx[ms] < 20) ? 0 : wx[ms] - 20;
         'h0E: wx[ms] = (wx[ms] + 20 > 639) ? 639 : wx[ms] + 20;
         'h09: wy[ms] = (wy[ms] < 20) ? 0 : wy[ms] - 20;
         'h11: wy[ms] = (wy[ms] + 20 > 479) ? 479 : wy[ms] + 20;
         'h10: wr[ms] = (wr[ms] - 5 < 5) ? 5 : wr[ms] - 5;
         'h12: wr[ms] = (wr[ms] + 5 > 200) ? 200 : wr[ms] + 5;
         'h00: ms = (ms + 1) % 4;
         'h01: wen[ms] = ~wen[ms];
         default: ;
      endcase
   endtask

   function automatic logic [11:0] exp_px(input int c, input int r);
      for (int i = 0; i < 4; i++) begin
         if (den[i] && ((c-dx[i])*(c-dx[i]) + (r-dy[i])*(r-dy[i]) <= dr[i]*dr[i]))
            return cols[i];
      end
      return 12'h000;
   endfunction

   task automatic check_sel(input string tag);
      chk({tag, "_sel"}, 32'(sel), 32'(ms));
      chk({tag, "_x"},   32'(sel_x), 32'(wx[ms]));
      chk({tag, "_y"},   32'(sel_y), 32'(wy[ms]));
      chk({tag, "_r"},   32'(sel_r), 32'(wr[ms]));
      chk({tag, "_en"},  32'(sel_en), 32'(wen[ms]));
   endtask

   task automatic press(input int c, input string tag);
      @(negedge clk);
      key_code  = 5'(c);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      apply_key(c);
      check_sel(tag);
   endtask

   task automatic frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      model_frame();
   endtask

   task automatic stream(input int c0, input int cstep, input int r0, input int n, input string tag);
      logic [11:0] e;
      for (int k = 0; k < n + 3; k++) begin
         @(negedge clk);
         if (k >= 3) begin
            e = q.pop_front();
            chk(tag, 32'(vga_data), 32'(e));
         end
         if (k < n) begin
            col_addr = 10'(c0 + k*cstep);
            row_addr = 9'(r0);
            q.push_back(exp_px(c0 + k*cstep, r0));
         end
      end
   endtask

   initial begin
      rstn = 1'b0; key_ready = 1'b1; key_code = 5'h0E; frame_start = 1'b0;
      col_addr = '0; row_addr = '0;
      model_reset();
      repeat (4) @(negedge clk);
      chk("reset_vga", 32'(vga_data), 32'h000);
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      chk("hold_through_reset_x", 32'(sel_x), 32'd128);
      key_ready = 1'b0;
      @(negedge clk);
      check_sel("reset");
      chk("reset_x_const", 32'(sel_x), 32'd128);

      frame();
      stream(128, 0, 240, 1, "center");
      stream(128, 0, 256, 1, "outside16");
      stream(143, 0, 240, 1, "edge15");
      stream(110, 3, 240, 16, "stream_row");

      @(negedge clk);
      key_code = 5'h0E; key_ready = 1'b1;
      repeat (100) @(negedge clk);
      key_ready = 1'b0;
      apply_key('h0E);
      check_sel("hold100");
      chk("hold100_x", 32'(sel_x), 32'd148);

      for (int i = 0; i < 8; i++) press('h0C, "xdec");
      chk("x_floor", 32'(sel_x), 32'd0);

      stream(128, 0, 240, 1, "shadow_pre");
      frame();
      stream(128, 0, 240, 1, "shadow_post");

      for (int i = 0; i < 40; i++) press('h12, "rinc");
      chk("r_ceiling", 32'(sel_r), 32'd200);
      for (int i = 0; i < 45; i++) press('h10, "rdec");
      chk("r_floor", 32'(sel_r), 32'd5);

      for (int i = 0; i < 3; i++) press('h00, "sel_step");
      chk("sel_three", 32'(sel), 32'd3);
      press('h00, "sel_wrap");
      chk("sel_wrapped", 32'(sel), 32'd0);

      press('h00, "sel_obj1");
      for (int i = 0; i < 13; i++) press('h0C, "move_obj1");
      frame();
      stream(0, 0, 240, 1, "overlap_prio");
      chk("overlap_prio_abs", 32'(exp_px(0, 240)), 32'hf00);
      for (int i = 0; i < 3; i++) press('h00, "sel_back");
      press('h01, "toggle0");
      frame();
      stream(0, 0, 240, 1, "overlap_disabled");

      @(negedge clk);
      key_code = 5'h01; key_ready = 1'b1; frame_start = 1'b1;
      @(negedge clk);
      key_ready = 1'b0; frame_start = 1'b0;
      model_frame();
      apply_key('h01);
      check_sel("simul_edit");
      stream(0, 0, 240, 1, "simul_pre");
      frame();
      stream(0, 0, 240, 1, "simul_post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
